// File: rtl/onehot_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder_pkg
// Description : Shared widths, FIFO occupancy encoding and result record
//               used by the one-hot encoder block.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_encoder_pkg;

    localparam int c_data_w = 16;
    localparam int c_idx_w  = 4;

    localparam logic [1:0] c_occ_empty = 2'd0;
    localparam logic [1:0] c_occ_one   = 2'd1;
    localparam logic [1:0] c_occ_full  = 2'd2;

    typedef struct packed {
        logic [c_idx_w-1:0] idx;
        logic               err;
    } enc_res_t;

endpackage
`default_nettype wire

// File: rtl/onehot_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder_if
// Description : Input/output handshake bundle of the one-hot encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface onehot_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    import onehot_encoder_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [c_data_w-1:0]  din;
    logic                 out_valid;
    logic                 out_ready;
    logic [c_idx_w-1:0]   dout;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout, out_err, err_cnt
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout, out_err, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/onehot_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : onehot_enc_core
// Description : Combinational 16-to-4 encode (highest set bit) and legality.
//               ONEHOT_ENC_PRIORITY_EN: multi-hot words are legal.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_enc_core
    import onehot_encoder_pkg::*;
(
    input  wire [c_data_w-1:0] i_din,
    output logic [c_idx_w-1:0] o_idx,
    output logic               o_err
);

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < c_data_w; i++) begin
            if (i_din[i]) begin
                o_idx = c_idx_w'(i);
            end
        end
    end

`ifdef ONEHOT_ENC_PRIORITY_EN
    assign o_err = (i_din == '0);
`else
    logic [c_idx_w:0] w_ones;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < c_data_w; i++) begin
            w_ones = w_ones + (c_idx_w + 1)'(i_din[i]);
        end
    end

    assign o_err = (w_ones != (c_idx_w + 1)'(1));
`endif

endmodule
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder
// Description : Registered one-hot to binary encoder with a 2-entry result
//               FIFO and saturating error counter. Macro: ONEHOT_ENC_PRIORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder
    import onehot_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  wire             clk,
    input  wire             rst_n,
    onehot_encoder_if.slave bus
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [c_idx_w-1:0]   w_enc_idx;
    logic                 w_enc_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    enc_res_t             r_res      [2];
    logic [ERR_CNT_W-1:0] r_cnt_snap [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;

    onehot_enc_core u_core (
        .i_din (bus.din),
        .o_idx (w_enc_idx),
        .o_err (w_enc_err)
    );

    assign w_push = bus.in_valid & w_in_ready;
    assign w_pop  = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_occ_empty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_occ_empty: if (w_push)            w_state_nxt = c_occ_one;
            c_occ_one: begin
                if (w_push && !w_pop)           w_state_nxt = c_occ_full;
                else if (!w_push && w_pop)      w_state_nxt = c_occ_empty;
            end
            c_occ_full:  if (w_pop)             w_state_nxt = c_occ_one;
            default:                            w_state_nxt = c_occ_empty;
        endcase
    end

    // Handshake flags depend on the state register only.
    always_comb begin
        w_in_ready  = (r_state != c_occ_full);
        w_out_valid = (r_state == c_occ_one) || (r_state == c_occ_full);
    end

    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (w_push && w_enc_err && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
        end
    end

    // Each entry keeps the counter value seen at its own accept, so the
    // presented count cannot move while the head result is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_res[i]      <= '0;
                r_cnt_snap[i] <= '0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
            if (w_push) begin
                r_res[r_wr_ptr]      <= '{idx: w_enc_idx, err: w_enc_err};
                r_cnt_snap[r_wr_ptr] <= w_err_cnt_nxt;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.dout      = w_out_valid ? r_res[r_rd_ptr].idx : '0;
    assign bus.out_err   = w_out_valid ? r_res[r_rd_ptr].err : 1'b0;
    assign bus.err_cnt   = w_out_valid ? r_cnt_snap[r_rd_ptr] : r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_encoder
// Description : Scoreboard bench for onehot_encoder (ERR_CNT_W 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder;

`ifdef ONEHOT_ENC_PRIORITY_EN
    localparam bit c_prio = 1'b1;
`else
    localparam bit c_prio = 1'b0;
`endif

    typedef struct {
        int idx;
        int err;
        int cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_acc;
    int   model_cnt;
    exp_t sb_q[$];

    bit       stall_prev;
    int       prev_dout;
    int       prev_err;
    int       prev_cnt;

    onehot_encoder_if #(.ERR_CNT_W(8)) if0 ();
    onehot_encoder_if #(.ERR_CNT_W(2)) if2 ();

    onehot_encoder #(.ERR_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    onehot_encoder #(.ERR_CNT_W(2)) dut_w2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: highest set bit index as floor(log2(w)); legality by popcount.
    function automatic int ref_idx(input logic [15:0] w);
        int v;
        int k;
        v = int'(w);
        k = 0;
        while (v > 1) begin
            v = v / 2;
            k++;
        end
        return k;
    endfunction

    function automatic int ref_err(input logic [15:0] w);
        int ones;
        ones = $countones(w);
        if (ones == 0) return 1;
        if (ones > 1 && !c_prio) return 1;
        return 0;
    endfunction

    function automatic logic [15:0] rand_word();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 16'h0001 << $urandom_range(0, 15);
        if (r == 6) return 16'h0000;
        return 16'($urandom());
    endfunction

    // Stimulus side: every accepted word pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && if0.in_valid && if0.in_ready) begin
            exp_t e;
            e.idx = ref_idx(if0.din);
            e.err = ref_err(if0.din);
            if (e.err == 1 && model_cnt < 255) model_cnt++;
            e.cnt = model_cnt;
            sb_q.push_back(e);
            n_acc++;
        end
    end

    // Monitor: pops on each output transfer, checks hold stability on stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && if0.out_valid) begin
                check("stall_dout", int'(if0.dout), prev_dout);
                check("stall_err", int'(if0.out_err), prev_err);
                check("stall_cnt", int'(if0.err_cnt), prev_cnt);
            end
            if (if0.out_valid && if0.out_ready) begin
                stall_prev = 1'b0;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_extra: got output dout=%0d with empty expected queue", if0.dout);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_dout", int'(if0.dout), e.idx);
                    check("sb_err", int'(if0.out_err), e.err);
                    check("sb_cnt", int'(if0.err_cnt), e.cnt);
                end
            end else if (if0.out_valid) begin
                stall_prev = 1'b1;
                prev_dout  = int'(if0.dout);
                prev_err   = int'(if0.out_err);
                prev_cnt   = int'(if0.err_cnt);
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        int cycles;
        int start_acc;
        int exp2[5];
        exp2 = '{1, 2, 3, 3, 3};
        n_checks      = 0;
        n_errors      = 0;
        n_acc         = 0;
        model_cnt     = 0;
        stall_prev    = 1'b0;
        rst_n         = 1'b0;
        if0.in_valid  = 1'b0;
        if0.din       = '0;
        if0.out_ready = 1'b0;
        if2.in_valid  = 1'b0;
        if2.din       = '0;
        if2.out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_in_ready", int'(if0.in_ready), 1);
        check("rst_out_valid", int'(if0.out_valid), 0);
        check("rst_dout", int'(if0.dout), 0);
        check("rst_out_err", int'(if0.out_err), 0);
        check("rst_err_cnt", int'(if0.err_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // One-hot sweep, one result per cycle
        if0.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if0.in_valid = 1'b1;
            if0.din      = 16'h0001 << k;
            tick();
            check("sweep_valid", int'(if0.out_valid), 1);
            check("sweep_dout", int'(if0.dout), k);
        end
        if0.in_valid = 1'b0;
        tick();
        tick();
        check("sweep_drained", int'(if0.out_valid), 0);
        check("sweep_err_cnt", int'(if0.err_cnt), 0);

        // Back-pressure: third word refused while FULL
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.din       = 16'h0010;
        tick();
        if0.din = 16'h0100;
        tick();
        check("full_in_ready", int'(if0.in_ready), 0);
        if0.din = 16'h1000;
        tick();
        if0.in_valid = 1'b0;
        tick();
        check("full_head_dout", int'(if0.dout), 4);
        if0.out_ready = 1'b1;
        tick();
        check("full_second_dout", int'(if0.dout), 8);
        tick();
        check("full_drained", int'(if0.out_valid), 0);

        // Zero word and multi-hot word
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.din       = 16'h0000;
        tick();
        if0.in_valid = 1'b0;
        check("zero_err", int'(if0.out_err), 1);
        check("zero_cnt", int'(if0.err_cnt), 1);
        check("zero_dout", int'(if0.dout), 0);
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.din       = 16'h8001;
        tick();
        if0.in_valid = 1'b0;
        check("multi_dout", int'(if0.dout), 15);
        check("multi_err", int'(if0.out_err), c_prio ? 0 : 1);
        if0.out_ready = 1'b1;
        tick();

        // Random traffic, 1000 words
        start_acc = n_acc;
        cycles    = 0;
        while ((n_acc - start_acc) < 1000 && cycles < 20000) begin
            if0.in_valid  = ($urandom_range(0, 9) < 7);
            if0.din       = rand_word();
            if0.out_ready = ($urandom_range(0, 9) < 7);
            tick();
            cycles++;
        end
        if (cycles >= 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL rand_timeout: got %0d accepts required 1000", n_acc - start_acc);
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        cycles = 0;
        while ((sb_q.size() != 0 || if0.out_valid) && cycles < 10) begin
            tick();
            cycles++;
        end
        check("rand_queue_left", sb_q.size(), 0);
        check("rand_out_valid", int'(if0.out_valid), 0);

        // Async reset with FIFO full, asserted between edges
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.din       = 16'h0000;
        tick();
        if0.din = 16'h0000;
        tick();
        if0.in_valid = 1'b0;
        check("prerst_full", int'(if0.in_ready), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        model_cnt = 0;
        #1;
        check("arst_out_valid", int'(if0.out_valid), 0);
        check("arst_err_cnt", int'(if0.err_cnt), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_in_ready", int'(if0.in_ready), 1);
        check("arst_post_valid", int'(if0.out_valid), 0);

        // Saturation with a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            if2.in_valid = 1'b1;
            if2.din      = 16'h0000;
            tick();
            if2.in_valid = 1'b0;
            check("w2_valid", int'(if2.out_valid), 1);
            check("w2_err_cnt", int'(if2.err_cnt), exp2[k]);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
